// File: rtl/switch_output_buffer_if.sv
// Link-side bundle for one switch output port: shifted flits in, link flits out, packet status.
// Master drives the crossbar side and the downstream stall; slave is the buffer.
interface switch_output_buffer_if #(
    parameter int FLIT_WIDTH = 32
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_valid;
    logic                  in_stall;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_valid;
    logic                  out_stall;
    logic                  port_locked;
    logic                  packet_done;
    logic                  proto_err;

    modport master (
        output in_flit, in_valid, out_stall,
        input  in_stall, out_flit, out_valid, port_locked, packet_done, proto_err
    );

    modport slave (
        input  in_flit, in_valid, out_stall,
        output in_stall, out_flit, out_valid, port_locked, packet_done, proto_err
    );
endinterface

// File: rtl/switch_output_buffer.sv
// Per-output-port circular flit FIFO with head/tail packet tracking for the output arbiter.
// Latency: a flit pushed at edge N is visible on out_flit after edge N; 1 flit/cycle sustained.
// Backpressure: in_stall when full (no bypass on simultaneous pop); out_flit held while out_stall.
module switch_output_buffer #(
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 6,
    parameter int PTR_WIDTH    = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    switch_output_buffer_if.slave  bus
);
    localparam int FTYPE_WD = 2;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(BUFFER_DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   FULL_CNT  = (PTR_WIDTH + 1)'(BUFFER_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [FLIT_WIDTH-1:0] mem [2**PTR_WIDTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH:0]    count;
    state_t                state;
    logic                  locked_q;
    logic                  done_q;
    logic                  err_q;

    logic                  full;
    logic                  not_empty;
    logic                  push;
    logic                  pop;
    logic [FTYPE_WD-1:0]   ftype;
    logic                  is_head;
    logic                  is_tail;

    // Status decodes depend only on count, so no input reaches in_stall/out_valid combinationally
    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);
    assign push      = bus.in_valid && !full;
    assign pop       = not_empty && !bus.out_stall;

    assign ftype   = bus.in_flit[FTYPE_WD-1:0];
    assign is_head = ftype[0];
    assign is_tail = ftype[1];

    assign bus.in_stall    = full;
    assign bus.out_valid   = not_empty;
    assign bus.out_flit    = not_empty ? mem[rd_ptr] : '0;
    assign bus.port_locked = locked_q;
    assign bus.packet_done = done_q;
    assign bus.proto_err   = err_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_flit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Packet framing tracks what enters the buffer; malformed flits are still stored and forwarded
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) begin
                case (state)
                    IDLE: begin
                        if (is_head && !is_tail) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end else if (is_head && is_tail) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (is_head) begin
                            err_q <= 1'b1;
                        end
                        if (is_tail) begin
                            state    <= IDLE;
                            locked_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_switch_output_buffer.sv
// Directed bench for switch_output_buffer: framing, full/stall handling, wrap, async reset.
module tb_switch_output_buffer;
    localparam int FW = 32;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    switch_output_buffer_if #(.FLIT_WIDTH(FW)) bus ();

    switch_output_buffer #(
        .FLIT_WIDTH(FW),
        .BUFFER_DEPTH(6),
        .PTR_WIDTH(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [29:0] p, input logic [1:0] t);
        return {p, t};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_flit   = '0;
        bus.in_valid  = 1'b0;
        bus.out_stall = 1'b0;
        #12;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.in_stall !== 1'b0) begin fails++; $display("FAIL rst_in_stall got %b want 0", bus.in_stall); end
        tests++; if (bus.port_locked !== 1'b0) begin fails++; $display("FAIL rst_port_locked got %b want 0", bus.port_locked); end
        tests++; if (bus.packet_done !== 1'b0) begin fails++; $display("FAIL rst_packet_done got %b want 0", bus.packet_done); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto_err got %b want 0", bus.proto_err); end
        tests++; if (bus.out_flit !== 32'h0) begin fails++; $display("FAIL rst_out_flit got %h want 0", bus.out_flit); end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_packet();
        bus.out_stall = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_flit   = mk(30'hA1, 2'b01);
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_no_bypass got %b want 0", bus.out_valid); end
        step();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid1 got %b want 1", bus.out_valid); end
        tests++; if (bus.out_flit !== mk(30'hA1, 2'b01)) begin fails++; $display("FAIL basic_flit1 got %h want %h", bus.out_flit, mk(30'hA1, 2'b01)); end
        tests++; if (bus.port_locked !== 1'b1) begin fails++; $display("FAIL basic_lock1 got %b want 1", bus.port_locked); end
        bus.in_flit = mk(30'hB2, 2'b00);
        step();
        tests++; if (bus.out_flit !== mk(30'hB2, 2'b00)) begin fails++; $display("FAIL basic_flit2 got %h want %h", bus.out_flit, mk(30'hB2, 2'b00)); end
        tests++; if (bus.port_locked !== 1'b1) begin fails++; $display("FAIL basic_lock2 got %b want 1", bus.port_locked); end
        tests++; if (bus.packet_done !== 1'b0) begin fails++; $display("FAIL basic_done_early got %b want 0", bus.packet_done); end
        bus.in_flit = mk(30'hC3, 2'b10);
        step();
        tests++; if (bus.out_flit !== mk(30'hC3, 2'b10)) begin fails++; $display("FAIL basic_flit3 got %h want %h", bus.out_flit, mk(30'hC3, 2'b10)); end
        tests++; if (bus.port_locked !== 1'b0) begin fails++; $display("FAIL basic_unlock got %b want 0", bus.port_locked); end
        tests++; if (bus.packet_done !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", bus.packet_done); end
        bus.in_valid = 1'b0;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got %b want 0", bus.out_valid); end
        tests++; if (bus.packet_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", bus.packet_done); end
    endtask

    task automatic test_full_and_release();
        logic [31:0] d [7];
        for (int i = 0; i < 7; i++) begin
            d[i] = mk(30'h100 + 30'(i), (i == 0) ? 2'b01 : ((i == 6) ? 2'b10 : 2'b00));
        end
        bus.out_stall = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_flit = d[i];
            step();
            tests++; if (bus.out_flit !== d[0]) begin fails++; $display("FAIL full_hold_%0d got %h want %h", i, bus.out_flit, d[0]); end
        end
        tests++; if (bus.in_stall !== 1'b1) begin fails++; $display("FAIL full_stall got %b want 1", bus.in_stall); end
        bus.in_flit = d[6];
        step();
        tests++; if (bus.in_stall !== 1'b1) begin fails++; $display("FAIL full_7th_held got %b want 1", bus.in_stall); end
        tests++; if (bus.out_flit !== d[0]) begin fails++; $display("FAIL full_hold_7 got %h want %h", bus.out_flit, d[0]); end
        // Full plus pop in the same cycle: push must be refused
        bus.out_stall = 1'b0;
        step();
        tests++; if (bus.in_stall !== 1'b0) begin fails++; $display("FAIL rel_unstall got %b want 0", bus.in_stall); end
        tests++; if (bus.out_flit !== d[1]) begin fails++; $display("FAIL rel_flit1 got %h want %h", bus.out_flit, d[1]); end
        tests++; if (bus.packet_done !== 1'b0) begin fails++; $display("FAIL rel_refused got %b want 0", bus.packet_done); end
        step();
        tests++; if (bus.out_flit !== d[2]) begin fails++; $display("FAIL rel_flit2 got %h want %h", bus.out_flit, d[2]); end
        tests++; if (bus.packet_done !== 1'b1) begin fails++; $display("FAIL rel_tail_done got %b want 1", bus.packet_done); end
        bus.in_valid = 1'b0;
        for (int k = 3; k < 7; k++) begin
            step();
            tests++; if (bus.out_flit !== d[k]) begin fails++; $display("FAIL rel_order_%0d got %h want %h", k, bus.out_flit, d[k]); end
        end
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rel_empty got %b want 0", bus.out_valid); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL rel_no_err got %b want 0", bus.proto_err); end
    endtask

    task automatic test_stream_wrap();
        logic [31:0] sf [20];
        int s;
        int r;
        int cnt;
        logic push_ok;
        logic pop_ok;
        s = 0; r = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            sf[i] = mk(30'h2000 + 30'(i * 7), (i == 0) ? 2'b01 : ((i == 19) ? 2'b10 : 2'b00));
        end
        for (int cyc = 0; cyc < 300 && r < 20; cyc++) begin
            bus.out_stall = ((cyc / 2) % 2) == 1;
            bus.in_valid  = (s < 20);
            bus.in_flit   = (s < 20) ? sf[s] : 32'h0;
            #1;
            tests++; if (bus.in_stall !== (cnt == 6)) begin fails++; $display("FAIL stream_stall c%0d got %b want %b", cyc, bus.in_stall, cnt == 6); end
            tests++; if (bus.out_valid !== (cnt != 0)) begin fails++; $display("FAIL stream_valid c%0d got %b want %b", cyc, bus.out_valid, cnt != 0); end
            push_ok = bus.in_valid && (cnt != 6);
            pop_ok  = (cnt != 0) && !bus.out_stall;
            if (pop_ok) begin
                tests++; if (bus.out_flit !== sf[r]) begin fails++; $display("FAIL stream_flit_%0d got %h want %h", r, bus.out_flit, sf[r]); end
                r++;
            end
            if (push_ok) s++;
            cnt = cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
            step();
        end
        tests++; if (r != 20) begin fails++; $display("FAIL stream_timeout got %0d want 20", r); end
        bus.in_valid  = 1'b0;
        bus.out_stall = 1'b0;
        step();
    endtask

    task automatic test_single_and_err();
        bus.out_stall = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_flit   = mk(30'h55, 2'b11);
        step();
        tests++; if (bus.packet_done !== 1'b1) begin fails++; $display("FAIL single_done got %b want 1", bus.packet_done); end
        tests++; if (bus.port_locked !== 1'b0) begin fails++; $display("FAIL single_lock got %b want 0", bus.port_locked); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL single_err got %b want 0", bus.proto_err); end
        bus.in_flit = mk(30'h66, 2'b01);
        step();
        tests++; if (bus.packet_done !== 1'b0) begin fails++; $display("FAIL single_done_once got %b want 0", bus.packet_done); end
        tests++; if (bus.port_locked !== 1'b1) begin fails++; $display("FAIL err_lock got %b want 1", bus.port_locked); end
        bus.in_flit = mk(30'h77, 2'b01);
        step();
        tests++; if (bus.proto_err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", bus.proto_err); end
        tests++; if (bus.port_locked !== 1'b1) begin fails++; $display("FAIL err_stay_locked got %b want 1", bus.port_locked); end
        tests++; if (bus.out_flit !== mk(30'h77, 2'b01)) begin fails++; $display("FAIL err_forwarded got %h want %h", bus.out_flit, mk(30'h77, 2'b01)); end
        bus.in_valid = 1'b0;
        step();
        step();
        tests++; if (bus.proto_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", bus.proto_err); end
    endtask

    task automatic test_async_reset();
        bus.out_stall = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_flit = mk(30'h300 + 30'(i), 2'b00);
            step();
        end
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid got %b want 1", bus.out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.port_locked !== 1'b0) begin fails++; $display("FAIL ar_lock got %b want 0", bus.port_locked); end
        tests++; if (bus.in_stall !== 1'b0) begin fails++; $display("FAIL ar_stall got %b want 0", bus.in_stall); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL ar_err got %b want 0", bus.proto_err); end
        tests++; if (bus.out_flit !== 32'h0) begin fails++; $display("FAIL ar_flit got %h want 0", bus.out_flit); end
        step();
        @(negedge clock);
        reset_n       = 1'b1;
        bus.out_stall = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_flit   = mk(30'h88, 2'b01);
        step();
        tests++; if (bus.out_flit !== mk(30'h88, 2'b01)) begin fails++; $display("FAIL ar_head_flit got %h want %h", bus.out_flit, mk(30'h88, 2'b01)); end
        tests++; if (bus.port_locked !== 1'b1) begin fails++; $display("FAIL ar_head_lock got %b want 1", bus.port_locked); end
        bus.in_flit = mk(30'h99, 2'b10);
        step();
        tests++; if (bus.packet_done !== 1'b1) begin fails++; $display("FAIL ar_tail_done got %b want 1", bus.packet_done); end
        tests++; if (bus.out_flit !== mk(30'h99, 2'b10)) begin fails++; $display("FAIL ar_tail_flit got %h want %h", bus.out_flit, mk(30'h99, 2'b10)); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL ar_clean_err got %b want 0", bus.proto_err); end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_packet();
        test_full_and_release();
        test_stream_wrap();
        test_single_and_err();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
